// File: rtl/fetch.sv
// -----------------------------------------------------------------------------
// fetch -- rv32i instruction fetch stage.
//
// Holds the PC and reads instruction words from memory over a req/gnt/rvalid
// interface, with at most one read outstanding. Each returned word is stored,
// together with its PC, in a one-entry output slot that feeds decode.
// Redirects from execute (taken branch/jump) move the PC, empty the slot and
// cancel any read still in flight.
//
// Handshakes:
//   imem: a read is issued in a cycle where imem_req_o && imem_gnt_i. While
//         req is high without gnt, req and addr do not change. The read data
//         comes back later, in order, as one cycle of imem_rvalid_i.
//   decode: the slot moves to decode in a cycle where
//         instr_valid_o && instr_ready_i. While valid is high and ready is low,
//         instruction_o and pc_o do not change.
//
// Parameters:
//   RESET_PC       PC of the first fetch after reset (word aligned)
//
// Ports:
//   clk_i, rst_i       clock; synchronous active-high reset
//   imem_req_o         read request
//   imem_addr_o        read word address (the PC)
//   imem_gnt_i         memory accepts the request this cycle
//   imem_rvalid_i      read data valid
//   imem_rdata_i       instruction word
//   instr_valid_o      output slot holds an instruction
//   instr_ready_i      decode takes the slot this cycle
//   instruction_o      instruction in the slot
//   pc_o               PC of instruction_o
//   redirect_i         load a new PC (highest priority)
//   redirect_pc_i      new PC
//   fetch_fault_o      (FETCH_MISALIGN_EN only) the slot holds a misaligned-
//                      target marker rather than a fetched word
//
// Build option FETCH_MISALIGN_EN: a redirect to a target that is not word
// aligned loads a NOP marker into the slot with fetch_fault_o set, and the
// stage stays idle until the next redirect. Without the option the two low
// bits of the target are ignored.
// -----------------------------------------------------------------------------
module fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instruction_o,
    output logic [31:0] pc_o,
`ifdef FETCH_MISALIGN_EN
    output logic        fetch_fault_o,
`endif
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,  // ready to issue a read at pc_q
        S_WAIT  = 2'd1,  // read outstanding, data will be kept
        S_DRAIN = 2'd2,  // read outstanding, data will be dropped
        S_FAULT = 2'd3   // idle after a misaligned redirect
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q;
    logic [31:0] pc_inflight_q;
    logic        can_issue;
    logic        load_slot;
    logic        redirect_bad;  // redirect to a target that is not word aligned
    logic        halt_next;     // leave DRAIN for FAULT rather than REQ

    // A read may only be started when the slot will be free by the time the
    // data returns; one read at a time makes this a single-cycle check.
    assign can_issue = !instr_valid_o || instr_ready_i;
    assign load_slot = (state_q == S_WAIT) && imem_rvalid_i && !redirect_i;

`ifdef FETCH_MISALIGN_EN
    logic halt_q;
    logic fault_q;

    assign redirect_bad  = redirect_i && (redirect_pc_i[1:0] != 2'b00);
    assign halt_next     = redirect_i ? redirect_bad : halt_q;
    assign fetch_fault_o = fault_q && instr_valid_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            halt_q <= 1'b0;
        end else begin
            halt_q <= halt_next;
        end
    end
`else
    assign redirect_bad = 1'b0;
    assign halt_next    = 1'b0;
`endif

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_REQ: begin
                if (imem_req_o && imem_gnt_i) state_d = S_WAIT;
            end
            S_WAIT: begin
                // Data arriving together with a redirect is dropped by the
                // datapath; the memory side is idle again either way.
                if (imem_rvalid_i)   state_d = S_REQ;
                else if (redirect_i) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                // A redirect here only moves the PC; the cancelled read
                // still has to come back before a new one may start.
                if (imem_rvalid_i) state_d = halt_next ? S_FAULT : S_REQ;
            end
            S_FAULT: begin
                if (redirect_i) state_d = S_REQ;
            end
            default: state_d = S_REQ;
        endcase
        // A misaligned target parks the stage, after any drain completes.
        if (redirect_bad && (state_d != S_DRAIN)) state_d = S_FAULT;
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        imem_req_o  = !rst_i && (state_q == S_REQ) && can_issue && !redirect_i;
        imem_addr_o = pc_q;
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q          <= RESET_PC;
            pc_inflight_q <= 32'h0;
            instr_valid_o <= 1'b0;
            instruction_o <= 32'h0;
            pc_o          <= 32'h0;
`ifdef FETCH_MISALIGN_EN
            fault_q       <= 1'b0;
`endif
        end else begin
            if (imem_req_o && imem_gnt_i) pc_inflight_q <= pc_q;

            if (redirect_i) begin
                pc_q          <= redirect_pc_i & ~32'h3;
                instr_valid_o <= 1'b0;
`ifdef FETCH_MISALIGN_EN
                if (redirect_bad) begin
                    instruction_o <= 32'h0000_0013;  // addi x0,x0,0
                    pc_o          <= redirect_pc_i;
                    instr_valid_o <= 1'b1;
                    fault_q       <= 1'b1;
                end
`endif
            end else if (load_slot) begin
                instruction_o <= imem_rdata_i;
                pc_o          <= pc_inflight_q;
                instr_valid_o <= 1'b1;
                pc_q          <= pc_q + 32'd4;
`ifdef FETCH_MISALIGN_EN
                fault_q       <= 1'b0;
`endif
            end else if (instr_valid_o && instr_ready_i) begin
                instr_valid_o <= 1'b0;
            end
        end
    end

endmodule
